// File: rtl/complement_pkg.sv
// Shared types and constants for the complement-to-sign-magnitude decoder.
package complement_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic ENC_TWOS = 1'b0;
    localparam logic ENC_ONES = 1'b1;

endpackage

// File: rtl/complement_bit_cell.sv
// One serial step of complement negation: a single input bit plus the running
// seen_one flag produce one magnitude bit and the updated flag.
module complement_bit_cell
    import complement_pkg::*;
(
    input  logic bit_in,
    input  logic mode,
    input  logic seen_in,
    output logic bit_out,
    output logic seen_out
);

    // Two's: bits up to and including the first 1 pass through, later ones flip.
    always_comb begin
        bit_out  = bit_in;
        seen_out = seen_in | bit_in;
        if (mode == ENC_ONES) begin
            bit_out = ~bit_in;
        end else if (seen_in) begin
            bit_out = ~bit_in;
        end
    end

endmodule

// File: rtl/complement_decoder.sv
// Decodes a ones'/two's-complement word into sign-magnitude, bit-serially by default.
// Define COMPLEMENT_DECODER_FAST_EN for a single-cycle combinational decode.
module complement_decoder
    import complement_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_ones,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sign,
    output logic [DATA_WIDTH-1:0] out_mag,
    output logic                  busy
);

    localparam int MSB = DATA_WIDTH - 1;

    state_t                  state;
    state_t                  state_next;
    logic                    sign_reg;
    logic [DATA_WIDTH-1:0]   mag_reg;
    logic                    in_neg;

    assign in_neg = in_data[MSB];

`ifdef COMPLEMENT_DECODER_FAST_EN
    logic [DATA_WIDTH:0]   seen_chain;
    logic [DATA_WIDTH-1:0] fast_mag;
    logic                  fast_sign;

    assign seen_chain[0] = 1'b0;

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_chain
        complement_bit_cell u_cell (
            .bit_in  (in_data[i]),
            .mode    (in_ones),
            .seen_in (seen_chain[i]),
            .bit_out (fast_mag[i]),
            .seen_out(seen_chain[i+1])
        );
    end

    // A zero magnitude (ones'-complement negative zero) must report a positive sign.
    assign fast_sign = seen_chain[DATA_WIDTH] & (|fast_mag);
`else
    localparam int                CNT_W    = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] data_reg;
    logic                  ones_reg;
    logic [CNT_W-1:0]      cnt;
    logic                  seen_one;
    logic                  cell_out;
    logic                  cell_seen;
    logic [DATA_WIDTH-1:0] shift_mag;

    complement_bit_cell u_cell (
        .bit_in  (data_reg[0]),
        .mode    (ones_reg),
        .seen_in (seen_one),
        .bit_out (cell_out),
        .seen_out(cell_seen)
    );

    // Result bits enter at the top so the LSB-first stream lands in place after DATA_WIDTH steps.
    assign shift_mag = {cell_out, mag_reg[DATA_WIDTH-1:1]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
`ifdef COMPLEMENT_DECODER_FAST_EN
                    state_next = DONE;
`else
                    state_next = in_neg ? SHIFT : DONE;
`endif
                end
            end
            SHIFT: begin
`ifdef COMPLEMENT_DECODER_FAST_EN
                state_next = IDLE;
`else
                if (cnt == LAST_BIT) begin
                    state_next = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_reg <= 1'b0;
            mag_reg  <= '0;
`ifdef COMPLEMENT_DECODER_FAST_EN
`else
            data_reg <= '0;
            ones_reg <= 1'b0;
            cnt      <= '0;
            seen_one <= 1'b0;
`endif
        end else if (state == IDLE && in_valid) begin
            sign_reg <= in_neg;
            if (!in_neg) begin
                mag_reg <= in_data;
            end else begin
`ifdef COMPLEMENT_DECODER_FAST_EN
                mag_reg  <= fast_mag;
                sign_reg <= fast_sign;
`else
                data_reg <= in_data;
                ones_reg <= in_ones;
                mag_reg  <= '0;
                cnt      <= '0;
                seen_one <= 1'b0;
`endif
            end
        end
`ifdef COMPLEMENT_DECODER_FAST_EN
`else
        else if (state == SHIFT) begin
            data_reg <= data_reg >> 1;
            mag_reg  <= shift_mag;
            seen_one <= cell_seen;
            cnt      <= cnt + CNT_W'(1);
            if (cnt == LAST_BIT) begin
                sign_reg <= sign_reg & (|shift_mag);
            end
        end
`endif
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_sign  = sign_reg;
    assign out_mag   = mag_reg;

endmodule

// File: tb/tb_complement_decoder.sv
// Directed self-checking bench for complement_decoder; serial or fast build
// (COMPLEMENT_DECODER_FAST_EN) selects the expected negative latency.
module tb_complement_decoder;
    import complement_pkg::*;

    localparam int DATA_WIDTH = 8;
`ifdef COMPLEMENT_DECODER_FAST_EN
    localparam int NEG_LAT = 1;
`else
    localparam int NEG_LAT = DATA_WIDTH + 1;
`endif

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ones;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_sign;
    logic [DATA_WIDTH-1:0] out_mag;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    complement_decoder #(.DATA_WIDTH(DATA_WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_ones  (in_ones),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sign (out_sign),
        .out_mag  (out_mag),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Called #1 after a rising edge with the block idle; leaves it holding the result in DONE.
    task automatic applyStimulus(input string tag, input logic [7:0] data, input logic ones,
                                 input logic exp_sign, input logic [7:0] exp_mag, input int exp_lat);
        int lat;
        checkOutput({tag, "_rdy"}, in_ready, 1);
        in_valid = 1'b1;
        in_data  = data;
        in_ones  = ones;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = ~data;
        in_ones  = ~ones;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, "_valid"}, out_valid, 1);
        checkOutput({tag, "_lat"}, lat, exp_lat);
        checkOutput({tag, "_sign"}, out_sign, exp_sign);
        checkOutput({tag, "_mag"}, out_mag, exp_mag);
        checkOutput({tag, "_busy"}, busy, 1);
        checkOutput({tag, "_blocked"}, in_ready, 0);
    endtask

    task automatic releaseOutput(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, "_rel_valid"}, out_valid, 0);
        checkOutput({tag, "_rel_rdy"}, in_ready, 1);
    endtask

    initial begin
        int stray;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ones   = ENC_TWOS;
        out_ready = 1'b0;
        #1;
        checkOutput("rst_rdy", in_ready, 1);
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_sign", out_sign, 0);
        checkOutput("rst_mag", out_mag, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus("twos_33", 8'h33, ENC_TWOS, 1'b0, 8'h33, 1);
        releaseOutput("twos_33");
        applyStimulus("twos_cc", 8'hCC, ENC_TWOS, 1'b1, 8'h34, NEG_LAT);
        releaseOutput("twos_cc");
        applyStimulus("ones_cc", 8'hCC, ENC_ONES, 1'b1, 8'h33, NEG_LAT);
        releaseOutput("ones_cc");
        applyStimulus("twos_80", 8'h80, ENC_TWOS, 1'b1, 8'h80, NEG_LAT);
        releaseOutput("twos_80");
        applyStimulus("ones_ff", 8'hFF, ENC_ONES, 1'b0, 8'h00, NEG_LAT);
        releaseOutput("ones_ff");
        applyStimulus("twos_ff", 8'hFF, ENC_TWOS, 1'b1, 8'h01, NEG_LAT);
        releaseOutput("twos_ff");
        applyStimulus("twos_81", 8'h81, ENC_TWOS, 1'b1, 8'h7F, NEG_LAT);
        releaseOutput("twos_81");
        applyStimulus("ones_00", 8'h00, ENC_ONES, 1'b0, 8'h00, 1);
        releaseOutput("ones_00");

        // Backpressure: a second word is offered while the result is held.
        applyStimulus("bp", 8'h85, ENC_ONES, 1'b1, 8'h7A, NEG_LAT);
        in_valid = 1'b1;
        in_data  = 8'h11;
        in_ones  = ENC_TWOS;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_hold_valid", out_valid, 1);
            checkOutput("bp_hold_sign", out_sign, 1);
            checkOutput("bp_hold_mag", out_mag, 8'h7A);
            checkOutput("bp_hold_rdy", in_ready, 0);
        end
        in_valid = 1'b0;
        releaseOutput("bp");
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) stray++;
        end
        checkOutput("bp_single_xfer", stray, 0);

        // Reset abort three cycles into the negative decode.
        in_valid = 1'b1;
        in_data  = 8'hCC;
        in_ones  = ENC_TWOS;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("abort_valid", out_valid, 0);
        checkOutput("abort_rdy", in_ready, 1);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_mag", out_mag, 0);
        checkOutput("abort_sign", out_sign, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) stray++;
        end
        checkOutput("abort_no_output", stray, 0);
        applyStimulus("post_05", 8'h05, ENC_TWOS, 1'b0, 8'h05, 1);
        releaseOutput("post_05");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
